// File: rtl/eightbit_counter_pkg.sv
// eightbit_counter_pkg: shared width, count constants and state type for the 8-bit T-FF counters
package eightbit_counter_pkg;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;
endpackage

// File: rtl/t_flipflop.sv
// t_flipflop: toggle flip-flop (CLK, async active-high Reset, T toggle enable, Q state)
module t_flipflop (
  input  logic CLK,
  input  logic Reset,
  input  logic T,
  output logic Q
);
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) Q <= 1'b0;
    else if (T) Q <= ~Q;
endmodule

// File: rtl/eightbit_down_counter_timer.sv
// eightbit_down_counter_timer: loadable 8-bit T-FF down-counter; ports CLK, Reset (async high), Load, Din, T, Q, Busy, Done; macro EIGHTBIT_DOWN_COUNTER_TIMER_AUTO_RELOAD_EN enables periodic reload
module eightbit_down_counter_timer
  import eightbit_counter_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             T,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done
);
  state_t           r_state;
  logic             r_done;
  logic             w_term;
  logic [WIDTH-1:0] w_dec_tog;
  logic [WIDTH-1:0] w_tog;
  assign Busy = (r_state == COUNT);
  assign Done = r_done;
  // Load has priority, so a collision with the terminal decrement never counts as terminal
  assign w_term = Busy && T && !Load && (Q == ONE);
  // Borrow chain: bit i toggles only when every lower bit is already zero
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_dec_tog[i] = Busy && T && ((Q & ((ONE << i) - ONE)) == ZERO);
    t_flipflop u_tff (.CLK(CLK), .Reset(Reset), .T(w_tog[i]), .Q(Q[i]));
  end
`ifdef EIGHTBIT_DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) r_reload <= ZERO;
    else if (Load) r_reload <= Din;
  assign w_tog = Load ? (Q ^ Din) : w_term ? (Q ^ r_reload) : w_dec_tog;
`else
  assign w_tog = Load ? (Q ^ Din) : w_dec_tog;
`endif
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_term;
      if (Load) r_state <= (Din != ZERO) ? COUNT : IDLE;
`ifdef EIGHTBIT_DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      else if (w_term) r_state <= COUNT;
`else
      else if (w_term) r_state <= IDLE;
`endif
    end
endmodule

// File: tb/tb_eightbit_down_counter_timer.sv
// tb_eightbit_down_counter_timer: table-driven and directed checks of the 8-bit down-counter/timer
module tb_eightbit_down_counter_timer;
`ifdef EIGHTBIT_DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       t;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic [7:0] din = 8'd0;
  logic       t = 1'b0;
  logic [7:0] q;
  logic       busy;
  logic       done;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];
  eightbit_down_counter_timer dut (
    .CLK(clk), .Reset(rst), .Load(ld), .Din(din), .T(t),
    .Q(q), .Busy(busy), .Done(done)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic l, logic [7:0] d, logic tt, logic [7:0] eq, logic eb, logic ed);
    vec_t r;
    r.ld = l; r.din = d; r.t = tt; r.q = eq; r.busy = eb; r.done = ed;
    return r;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(logic l, logic [7:0] d, logic tt);
    @(negedge clk);
    ld = l; din = d; t = tt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(string nm, logic [7:0] eq, logic eb, logic ed);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_busy"}, busy, eb);
    chk({nm, "_done"}, done, ed);
  endtask
  initial begin
    int edges;
    // single-shot / reload countdown from 5
    tbl.push_back(v(1, 5, 1, 5, 1, 0));
    tbl.push_back(v(0, 0, 1, 4, 1, 0));
    tbl.push_back(v(0, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 0, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, AUTO ? 8'd5 : 8'd0, AUTO, 1));
    if (!AUTO) for (int i = 0; i < 10; i++) tbl.push_back(v(0, 0, 1, 0, 0, 0));
    // enable gaps
    tbl.push_back(v(1, 4, 0, 4, 1, 0));
    tbl.push_back(v(0, 0, 1, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 0, 1, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, AUTO ? 8'd4 : 8'd0, AUTO, 1));
    tbl.push_back(v(0, 0, 0, AUTO ? 8'd4 : 8'd0, AUTO, 0));
    // load zero, then load colliding with terminal decrement
    tbl.push_back(v(1, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 2, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 0));
    tbl.push_back(v(1, 9, 1, 9, 1, 0));
    tbl.push_back(v(0, 0, 0, 9, 1, 0));
    tbl.push_back(v(0, 0, 1, 8, 1, 0));
    // auto-reload period from 3 (single-shot ends at 0 after third edge)
    tbl.push_back(v(1, 3, 0, 3, 1, 0));
    for (int i = 1; i <= 9; i++) begin
      logic [7:0] eq;
      eq = 8'(3 - ((i - 1) % 3 + 1) % 3);
      if (!AUTO && i >= 3) tbl.push_back(v(0, 0, 1, 0, 0, i == 3));
      else tbl.push_back(v(0, 0, 1, eq, 1, (i % 3) == 0));
    end
    #3;
    chk_all("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[k]) begin
      step(tbl[k].ld, tbl[k].din, tbl[k].t);
      chk_all($sformatf("vec%0d", k), tbl[k].q, tbl[k].busy, tbl[k].done);
    end
    // full range: borrow across all bits, terminal after exactly 255 enabled edges
    step(1, 255, 0);
    chk("full_load", q, 255);
    edges = 0;
    for (int k = 1; k <= 260; k++) begin
      step(0, 0, 1);
      if (done) begin
        edges = k;
        break;
      end
      chk("full_q", q, 255 - k);
    end
    chk("full_edges", edges, 255);
    chk("full_term_q", q, AUTO ? 255 : 0);
    chk("full_term_busy", busy, AUTO);
    // asynchronous reset mid-countdown at Q=7
    step(1, 10, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("pre_reset_q", q, 7);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      chk_all("post_reset", 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eightbit_down_counter_timer.md
# eightbit_down_counter_timer

8-bit loadable down-counter/timer built from T flip-flops. It counts a programmed value down to zero at one step per enabled clock and emits a one-cycle Done pulse on terminal count. It is the countdown counterpart to the team's 8-bit T flip-flop up-counter and sits beside it as a programmable interval/timeout source for lab-level control logic.

## Interface
Parameters:
- none (width fixed at 8 bits)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Load  input  1  load Din into the counter and reload register; priority over T
- Din  input  8  load value (unsigned)
- T  input  1  count enable; one decrement per rising edge while high and Busy
- Q  output  8  current count value
- Busy  output  1  high while a countdown is in progress (state COUNT)
- Done  output  1  registered one-cycle pulse on terminal count

## Operation
- States: IDLE, COUNT.
- Reset (async, any time): Q=0, reload register=0, Done=0, Busy=0, state=IDLE. Reset mid-countdown aborts it; no Done is produced.
- Load=1 (either state):
  - next edge: Q=Din, reload=Din, Done=0.
  - state becomes COUNT if Din!=0, otherwise IDLE.
  - T is ignored that cycle.
- COUNT, Load=0, T=0: Q holds, Done=0.
- COUNT, Load=0, T=1, Q>1: Q=Q-1, Done=0.
- COUNT, Load=0, T=1, Q==1 (terminal):
  - Done=1 for exactly that next cycle.
  - Q and state follow the configuration rules (see Configuration).
- IDLE, Load=0: Q holds; T ignored; Q never wraps 0→255; Done=0.
- Decrement implemented by toggling: bit i toggles when T is high, the counter is Busy, and bits 0..i-1 are all 0.
- Load implemented by toggling: toggle_i = Q[i] XOR Din[i]. All updates go through the T flip-flops only.
- Busy is combinational from the state register: Busy = (state==COUNT).

## Timing
- Load-to-Q latency: 1 cycle.
- Countdown from N with T held high:
  - Q reads N, N-1, …, 1 on successive cycles after load.
  - Terminal edge is the N-th enabled edge after load.
  - Done is high in the cycle after that edge.
- Gaps in T stretch the countdown 1:1 with no skipped or double steps.
- Load on the same edge as a terminal decrement: Load wins, no Done, new value taken.
- Done is a registered output, never combinational from T.

## Configuration
- Macro: EIGHTBIT_DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
- Defined:
  - at terminal count, Q=reload value, Done pulses, state stays COUNT.
  - Periodic Done every N enabled cycles.
  - Reload is always nonzero here, because COUNT is only entered with Din!=0.
- Undefined:
  - at terminal count, Q=0 and state=IDLE; single-shot.
  - The reload register may still exist but is unused.

## Structure
- Shared package eightbit_counter_pkg holds:
  - state typedef (IDLE, COUNT)
  - WIDTH=8 constant
  - ZERO/ONE count constants
- Sub-module: reuse existing t_flipflop (CLK, Reset, T, Q), instantiated 8 times for Q.
- Next-state logic, per-bit toggle terms, Done/state/reload registers live in this module.

## Test plan
- Reset: assert Reset asynchronously mid-cycle during COUNT at Q=7 -> Q=0, Busy=0, Done=0 immediately; T has no effect afterwards until the next Load.
- Single-shot (macro undefined): Load Din=5, then T=1 continuously -> Q=5,4,3,2,1,0; Done high one cycle alongside Q=0; Busy falls with it; Q stays 0 for 10 more cycles (no wrap).
- Enable gaps: Load Din=4, T pattern 1,0,0,1,1,0,1 -> Q=4,3,3,3,2,1,1,0; Done only in the Q=0 cycle.
- Load 0 and collision:
  - Load Din=0 -> Q=0, Busy=0, no Done.
  - Load Din=9 on the edge where Q goes 1→0 -> Q=9, Busy=1, no Done.
- Full range: Load Din=255, T=1 -> Done after exactly 255 enabled edges; borrow across all bits is correct at 128→127 and 16→15.
- Auto-reload (macro defined): Load Din=3, T=1 for 9 edges -> Q=3,2,1,3,2,1,3,2,1,3; Done pulses 3 times, period 3; Busy stays 1.
